// File: rtl/clk_ctrl_pkg.sv
// Shared types and default timing for the alarm clock mode sequencer.
package clk_ctrl_pkg;

    typedef enum logic [2:0] {RUN, SET_HRS, SET_MIN, ALM_HRS, ALM_MIN} mode_t;
    typedef enum logic [1:0] {A_IDLE, A_RING, A_SNOOZE} alarm_t;

    localparam int HOLD_T_DEF   = 2;
    localparam int IDLE_TO_DEF  = 30;
    localparam int RING_S_DEF   = 60;
    localparam int SNOOZE_S_DEF = 300;

    // Mode ring order: RUN -> SET_HRS -> SET_MIN -> ALM_HRS -> ALM_MIN -> RUN
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            RUN:     return SET_HRS;
            SET_HRS: return SET_MIN;
            SET_MIN: return ALM_HRS;
            ALM_HRS: return ALM_MIN;
            default: return RUN;
        endcase
    endfunction

    function automatic logic is_alm(input mode_t m);
        return (m == ALM_HRS) || (m == ALM_MIN);
    endfunction

    function automatic logic is_tset(input mode_t m);
        return (m == SET_HRS) || (m == SET_MIN);
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Button edge detect with hold-to-repeat: one strobe on press, then one per
// tick once the button has been held for HOLD_T ticks.
module btn_repeat
    import clk_ctrl_pkg::*;
#(
    parameter int HOLD_T = HOLD_T_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    input  logic tick_i,
    input  logic en_i,     // field is editable (not RUN)
    input  logic clr_i,    // mode is changing this cycle
    output logic edge_o,
    output logic fire_o
);
    localparam int CW = $clog2(HOLD_T + 1);

    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          held;

    assign edge_o = btn_i & ~prev_q;
    assign held   = en_i & btn_i & ~clr_i;
    assign fire_o = en_i & ~clr_i & (edge_o | (btn_i & tick_i & (cnt_q >= CW'(HOLD_T))));

    // Hold counter: counts ticks while held, saturates at HOLD_T, clears otherwise
    always_comb begin
        cnt_d = cnt_q;
        if (!held)
            cnt_d = '0;
        else if (tick_i && (cnt_q < CW'(HOLD_T)))
            cnt_d = cnt_q + 1'b1;
    end

    // prev resets high so a button held through reset produces no edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            prev_q <= btn_i;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/clock_ctrl_fsm.sv
// Alarm clock mode sequencer (time/alarm set controls) and alarm scheduler
// (ring timeout, snooze). All outputs are registered.
module clock_ctrl_fsm
    import clk_ctrl_pkg::*;
#(
    parameter int HOLD_T   = HOLD_T_DEF,
    parameter int IDLE_TO  = IDLE_TO_DEF,
    parameter int RING_S   = RING_S_DEF,
    parameter int SNOOZE_S = SNOOZE_S_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       mode_btn_i,
    input  logic       adv_btn_i,
    input  logic       snooze_btn_i,
    input  logic       alarm_on_i,
    input  logic       alarm_match_i,
    output logic       timeset_o,
    output logic       alarmset_o,
    output logic       hrsadv_o,
    output logic       minadv_o,
    output logic       buzz_o,
    output logic       blink_o,
    output logic [2:0] mode_o
);
    localparam int IW = $clog2(IDLE_TO + 1);
    localparam int RW = $clog2(RING_S + 1);
    localparam int SW = $clog2(SNOOZE_S + 1);

    mode_t         mode_q, mode_d;
    alarm_t        alarm_q, alarm_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [RW-1:0] ring_q, ring_d;
    logic [SW-1:0] snz_q, snz_d;
    logic          mode_prev_q, snz_prev_q, match_prev_q;
    logic          mode_edge, snz_edge, match_edge, adv_edge, adv_fire, mode_chg;
    logic          timeset_q, alarmset_q, hrsadv_q, minadv_q, buzz_q, blink_q, blink_d;

    assign mode_edge  = mode_btn_i & ~mode_prev_q;
    assign snz_edge   = snooze_btn_i & ~snz_prev_q;
    assign match_edge = alarm_match_i & ~match_prev_q;
    assign mode_chg   = (mode_d != mode_q);

    btn_repeat #(.HOLD_T(HOLD_T)) u_adv (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .btn_i  (adv_btn_i),
        .tick_i (tick_i),
        .en_i   (mode_q != RUN),
        .clr_i  (mode_chg),
        .edge_o (adv_edge),
        .fire_o (adv_fire)
    );

    // Mode sequencing and idle timeout back to RUN
    always_comb begin
        mode_d = mode_q;
        idle_d = idle_q;
        if (mode_q == RUN) begin
            idle_d = '0;
            if (mode_edge) mode_d = SET_HRS;
        end else if (mode_edge || adv_edge || snz_edge) begin
            idle_d = '0;
            if (mode_edge) mode_d = next_mode(mode_q);
        end else if (tick_i) begin
            if (idle_q >= IW'(IDLE_TO - 1)) begin
                mode_d = RUN;
                idle_d = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    // Alarm scheduler: switch-off and alarm editing override everything
    always_comb begin
        alarm_d = alarm_q;
        ring_d  = ring_q;
        snz_d   = snz_q;
        if (!alarm_on_i || is_alm(mode_d)) begin
            alarm_d = A_IDLE;
            ring_d  = '0;
            snz_d   = '0;
        end else begin
            case (alarm_q)
                A_IDLE: if (match_edge && !is_alm(mode_q)) begin
                    alarm_d = A_RING;
                    ring_d  = '0;
                end
                A_RING: if (snz_edge) begin
                    alarm_d = A_SNOOZE;
                    snz_d   = SW'(SNOOZE_S);
                end else if (tick_i) begin
                    if (ring_q >= RW'(RING_S - 1)) begin
                        alarm_d = A_IDLE;
                        ring_d  = '0;
                    end else begin
                        ring_d = ring_q + 1'b1;
                    end
                end
                A_SNOOZE: if (snz_q == '0 || (tick_i && snz_q == SW'(1))) begin
                    alarm_d = A_RING;
                    ring_d  = '0;
                    snz_d   = '0;
                end else if (tick_i) begin
                    snz_d = snz_q - 1'b1;
                end
                default: alarm_d = A_IDLE;
            endcase
        end
    end

    // Blink restarts low on every mode entry, toggles per tick, low in RUN
    always_comb begin
        blink_d = blink_q;
        if (mode_d == RUN || mode_chg)
            blink_d = 1'b0;
        else if (tick_i)
            blink_d = ~blink_q;
    end

    // State, edge history and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q       <= RUN;
            alarm_q      <= A_IDLE;
            idle_q       <= '0;
            ring_q       <= '0;
            snz_q        <= '0;
            mode_prev_q  <= 1'b1;
            snz_prev_q   <= 1'b1;
            match_prev_q <= 1'b1;
            timeset_q    <= 1'b0;
            alarmset_q   <= 1'b0;
            hrsadv_q     <= 1'b0;
            minadv_q     <= 1'b0;
            buzz_q       <= 1'b0;
            blink_q      <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            alarm_q      <= alarm_d;
            idle_q       <= idle_d;
            ring_q       <= ring_d;
            snz_q        <= snz_d;
            mode_prev_q  <= mode_btn_i;
            snz_prev_q   <= snooze_btn_i;
            match_prev_q <= alarm_match_i;
            timeset_q    <= is_tset(mode_d);
            alarmset_q   <= is_alm(mode_d);
            hrsadv_q     <= adv_fire & ((mode_q == SET_HRS) || (mode_q == ALM_HRS));
            minadv_q     <= adv_fire & ((mode_q == SET_MIN) || (mode_q == ALM_MIN));
            buzz_q       <= (alarm_d == A_RING);
            blink_q      <= blink_d;
        end
    end

    assign timeset_o  = timeset_q;
    assign alarmset_o = alarmset_q;
    assign hrsadv_o   = hrsadv_q;
    assign minadv_o   = minadv_q;
    assign buzz_o     = buzz_q;
    assign blink_o    = blink_q;
    assign mode_o     = mode_q;

endmodule

// File: tb/tb_clock_ctrl_fsm.sv
// Bench for clock_ctrl_fsm: behavioural model checked every cycle, directed
// scenarios with literal expectations, then randomized button traffic.
module tb_clock_ctrl_fsm;
    localparam int HOLD_T   = 2;
    localparam int IDLE_TO  = 30;
    localparam int RING_S   = 60;
    localparam int SNOOZE_S = 300;

    logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
    logic mode_btn = 1'b0, adv_btn = 1'b0, snz_btn = 1'b0, alarm_on = 1'b0, match = 1'b0;
    logic timeset, alarmset, hrsadv, minadv, buzz, blink;
    logic [2:0] mode;

    int vectors = 0, miscompares = 0;
    int tick_period = 2;
    int hadv_cnt = 0, madv_cnt = 0;

    always #5 clk = ~clk;

    clock_ctrl_fsm #(.HOLD_T(HOLD_T), .IDLE_TO(IDLE_TO), .RING_S(RING_S), .SNOOZE_S(SNOOZE_S)) dut (
        .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .mode_btn_i(mode_btn), .adv_btn_i(adv_btn),
        .snooze_btn_i(snz_btn), .alarm_on_i(alarm_on), .alarm_match_i(match),
        .timeset_o(timeset), .alarmset_o(alarmset), .hrsadv_o(hrsadv), .minadv_o(minadv),
        .buzz_o(buzz), .blink_o(blink), .mode_o(mode)
    );

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // modes 0..4 = RUN, SET_HRS, SET_MIN, ALM_HRS, ALM_MIN; alarm 0 idle, 1 ringing, 2 snoozed
    int m_mode, m_alarm, m_idle, m_hold, m_ring, m_snz;
    bit pm, pa, ps, pmt, m_blink;
    bit e_ts, e_as, e_h, e_m, e_bz, e_bl;

    task automatic model_reset();
        m_mode = 0; m_alarm = 0; m_idle = 0; m_hold = 0; m_ring = 0; m_snz = 0;
        pm = 1; pa = 1; ps = 1; pmt = 1; m_blink = 0;
        e_ts = 0; e_as = 0; e_h = 0; e_m = 0; e_bz = 0; e_bl = 0;
    endtask

    task automatic model_step();
        bit me, ae, se, mte, in_set, chg, fire;
        int nm;
        me = mode_btn && !pm; ae = adv_btn && !pa; se = snz_btn && !ps; mte = match && !pmt;
        in_set = (m_mode != 0);
        nm = m_mode;
        if (me) nm = (m_mode + 1) % 5;
        else if (in_set && !ae && !se && tick && (m_idle + 1 == IDLE_TO)) nm = 0;
        chg = (nm != m_mode);
        // ticks of inactivity while editing
        if (!in_set || me || ae || se || chg) m_idle = 0;
        else if (tick) m_idle++;
        // press strobe, then one strobe per tick after HOLD_T held ticks
        fire = in_set && !chg && (ae || (adv_btn && tick && m_hold >= HOLD_T));
        if (!in_set || !adv_btn || chg) m_hold = 0;
        else if (tick && m_hold < HOLD_T) m_hold++;
        e_h = fire && (m_mode == 1 || m_mode == 3);
        e_m = fire && (m_mode == 2 || m_mode == 4);
        if (!alarm_on || nm == 3 || nm == 4) m_alarm = 0;
        else case (m_alarm)
            0: if (mte && !(m_mode == 3 || m_mode == 4)) begin m_alarm = 1; m_ring = 0; end
            1: if (se) begin m_alarm = 2; m_snz = SNOOZE_S; end
               else if (tick) begin m_ring++; if (m_ring == RING_S) m_alarm = 0; end
            2: if (tick) begin m_snz--; if (m_snz == 0) begin m_alarm = 1; m_ring = 0; end end
            default: m_alarm = 0;
        endcase
        if (nm == 0 || chg) m_blink = 0;
        else if (tick) m_blink = !m_blink;
        m_mode = nm;
        e_ts = (nm == 1 || nm == 2); e_as = (nm == 3 || nm == 4);
        e_bz = (m_alarm == 1); e_bl = m_blink;
        pm = mode_btn; pa = adv_btn; ps = snz_btn; pmt = match;
    endtask

    // Every-cycle compare, sampled 1 time unit after the rising edge
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset(); else model_step();
            #1;
            if (hrsadv) hadv_cnt++;
            if (minadv) madv_cnt++;
            chk("mode", int'(mode), m_mode);
            chk("timeset", timeset, e_ts);
            chk("alarmset", alarmset, e_as);
            chk("hrsadv", hrsadv, e_h);
            chk("minadv", minadv, e_m);
            chk("buzz", buzz, e_bz);
            chk("blink", blink, e_bl);
        end
    end

    // 1 Hz strobe stand-in: one cycle high every tick_period cycles
    initial begin
        int c = 0;
        forever begin
            @(negedge clk);
            c++;
            tick = rst_n && ((c % tick_period) == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) @(posedge clk iff tick);
        @(negedge clk);
    endtask

    task automatic pulse_mode();
        mode_btn = 1'b1; @(negedge clk);
        mode_btn = 1'b0; @(negedge clk);
    endtask

    task automatic ring_now();
        match = 1'b0; @(negedge clk);
        match = 1'b1; @(negedge clk);
    endtask

    initial begin
        // reset with mode_btn held through it
        rst_n = 1'b0; mode_btn = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mode", int'(mode), 0);
        chk("rst_buzz", buzz, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("held_thru_rst", int'(mode), 0);
        mode_btn = 1'b0; @(negedge clk);

        // mode cycling
        for (int i = 1; i <= 5; i++) begin
            pulse_mode();
            chk("cyc_mode", int'(mode), i % 5);
            chk("cyc_ts", timeset, int'(i == 1 || i == 2));
            chk("cyc_as", alarmset, int'(i == 3 || i == 4));
        end

        // auto-repeat in SET_MIN: 6 held ticks -> 1 + 4 strobes
        pulse_mode(); pulse_mode();
        chk("setmin_mode", int'(mode), 2);
        hadv_cnt = 0; madv_cnt = 0;
        adv_btn = 1'b1; wait_ticks(6); adv_btn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rep_minadv", madv_cnt, 5);
        chk("rep_hrsadv", hadv_cnt, 0);

        // idle timeout from SET_HRS
        pulse_mode(); pulse_mode(); pulse_mode();
        chk("back_run", int'(mode), 0);
        pulse_mode();
        wait_ticks(IDLE_TO - 1);
        chk("idle_29", int'(mode), 1);
        wait_ticks(1);
        chk("idle_30", int'(mode), 0);

        // mode and adv edges together: mode wins, no strobe
        pulse_mode();
        hadv_cnt = 0; madv_cnt = 0;
        mode_btn = 1'b1; adv_btn = 1'b1; @(negedge clk);
        mode_btn = 1'b0; adv_btn = 1'b0; @(negedge clk);
        chk("both_mode", int'(mode), 2);
        repeat (2) @(negedge clk);
        chk("both_strobes", hadv_cnt + madv_cnt, 0);
        pulse_mode(); pulse_mode(); pulse_mode();

        // alarm, snooze, re-ring, timeout, persistent match
        alarm_on = 1'b1;
        ring_now();
        chk("alm_buzz", buzz, 1);
        snz_btn = 1'b1; @(negedge clk); snz_btn = 1'b0;
        chk("snz_off", buzz, 0);
        wait_ticks(SNOOZE_S - 1);
        chk("snz_299", buzz, 0);
        wait_ticks(1);
        chk("snz_300", buzz, 1);
        wait_ticks(RING_S - 1);
        chk("ring_59", buzz, 1);
        wait_ticks(1);
        chk("ring_60", buzz, 0);
        repeat (10) @(negedge clk);
        chk("no_reret", buzz, 0);

        // alarm_on drop beats snooze: goes idle, never re-rings
        ring_now();
        chk("pri_buzz", buzz, 1);
        alarm_on = 1'b0; snz_btn = 1'b1; @(negedge clk);
        snz_btn = 1'b0; alarm_on = 1'b1;
        chk("pri_off", buzz, 0);
        wait_ticks(SNOOZE_S + 10);
        chk("pri_idle", buzz, 0);

        // entering alarm-set while ringing silences
        ring_now();
        chk("ent_buzz", buzz, 1);
        pulse_mode(); pulse_mode(); pulse_mode();
        chk("ent_alm_buzz", buzz, 0);
        chk("ent_alm_as", alarmset, 1);
        pulse_mode(); pulse_mode();

        // async reset mid-ring
        ring_now();
        chk("rr_buzz", buzz, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_buzz0", buzz, 0);
        chk("rr_mode0", int'(mode), 0);
        chk("rr_outs0", int'({timeset, alarmset, hrsadv, minadv, blink}), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // randomized traffic: busy buttons, then sparse buttons for long timeouts
        tick_period = 3;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) mode_btn = ~mode_btn;
            if ($urandom_range(0, 7) == 0) adv_btn = ~adv_btn;
            if ($urandom_range(0, 15) == 0) snz_btn = ~snz_btn;
            if ($urandom_range(0, 99) == 0) alarm_on = ~alarm_on;
            if ($urandom_range(0, 40) == 0) match = ~match;
        end
        tick_period = 2;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 149) == 0) mode_btn = ~mode_btn;
            if ($urandom_range(0, 39) == 0) adv_btn = ~adv_btn;
            if ($urandom_range(0, 299) == 0) snz_btn = ~snz_btn;
            if ($urandom_range(0, 799) == 0) alarm_on = ~alarm_on;
            if ($urandom_range(0, 59) == 0) match = ~match;
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
